// File: rtl/draw_pkg.sv
// Shared types and constants for the Bresenham line rasteriser.
package draw_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int X_W_DEF  = 10;
  localparam int Y_W_DEF  = 9;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  // Two bits beyond the widest coordinate hold the sign plus the doubled error term.
  localparam int ERR_W = ((X_W_DEF > Y_W_DEF) ? X_W_DEF : Y_W_DEF) + 2;

  typedef logic signed [ERR_W-1:0] err_t;

endpackage

// File: rtl/clamp_coord.sv
// Saturates a coordinate to the largest legal value on its axis.
module clamp_coord #(
  parameter int W   = 10,
  parameter int MAX = 639
) (
  input  logic [W-1:0] value_i,
  output logic [W-1:0] value_o
);

  localparam logic [W-1:0] MaxV = W'(MAX);

  assign value_o = (value_i > MaxV) ? MaxV : value_i;

endmodule

// File: rtl/line_draw_engine.sv
// Bresenham line rasteriser: one line request in, one pixel per valid/ready handshake out.
// write_done stays high after the final pixel until the next request or reset.
module line_draw_engine
  import draw_pkg::*;
#(
  parameter int X_W   = X_W_DEF,
  parameter int Y_W   = Y_W_DEF,
  parameter int X_MAX = SCREEN_W - 1,
  parameter int Y_MAX = SCREEN_H - 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [X_W-1:0] x0,
  input  logic [Y_W-1:0] y0,
  input  logic [X_W-1:0] x1,
  input  logic [Y_W-1:0] y1,
  output logic [X_W-1:0] pixel_x,
  output logic [Y_W-1:0] pixel_y,
  output logic           pixel_valid,
  input  logic           pixel_ready,
  output logic           busy,
  output logic           write_done,
  output logic [X_W:0]   pixel_count
);

  state_e state_q, state_d;

  logic [X_W-1:0] x0_clamp, x1_clamp;
  logic [Y_W-1:0] y0_clamp, y1_clamp;

  logic [X_W-1:0] xs_q, xs_d, xe_q, xe_d, cx_q, cx_d;
  logic [Y_W-1:0] ys_q, ys_d, ye_q, ye_d, cy_q, cy_d;
  err_t           dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  err_t           e2;
  logic           sx_q, sx_d, sy_q, sy_d;
  logic [X_W:0]   cnt_q, cnt_d;

  logic in_draw, xfer, at_end, step_x, step_y;

  clamp_coord #(.W(X_W), .MAX(X_MAX)) u_clamp_x0 (.value_i(x0), .value_o(x0_clamp));
  clamp_coord #(.W(Y_W), .MAX(Y_MAX)) u_clamp_y0 (.value_i(y0), .value_o(y0_clamp));
  clamp_coord #(.W(X_W), .MAX(X_MAX)) u_clamp_x1 (.value_i(x1), .value_o(x1_clamp));
  clamp_coord #(.W(Y_W), .MAX(Y_MAX)) u_clamp_y1 (.value_i(y1), .value_o(y1_clamp));

  assign in_draw = (state_q == DRAW);
  assign xfer    = in_draw & pixel_ready;
  assign at_end  = (cx_q == xe_q) && (cy_q == ye_q);

  // Both axis decisions look at the same pre-update error term.
  assign e2     = err_q <<< 1;
  assign step_x = (e2 >= dy_q);
  assign step_y = (e2 <= dx_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = SETUP;
      SETUP:      state_d = DRAW;
      DRAW:       if (xfer && at_end) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    pixel_valid = in_draw;
    busy        = (state_q == SETUP) || in_draw;
    write_done  = (state_q == DONE);
    pixel_x     = cx_q;
    pixel_y     = cy_q;
    pixel_count = cnt_q;
  end

  always_comb begin
    xs_d  = xs_q;
    ys_d  = ys_q;
    xe_d  = xe_q;
    ye_d  = ye_q;
    cx_d  = cx_q;
    cy_d  = cy_q;
    dx_d  = dx_q;
    dy_d  = dy_q;
    err_d = err_q;
    sx_d  = sx_q;
    sy_d  = sy_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          xs_d  = x0_clamp;
          ys_d  = y0_clamp;
          xe_d  = x1_clamp;
          ye_d  = y1_clamp;
          cnt_d = '0;
        end
      end
      SETUP: begin
        dx_d  = (xe_q >= xs_q) ? err_t'(xe_q - xs_q) : err_t'(xs_q - xe_q);
        dy_d  = (ye_q >= ys_q) ? -err_t'(ye_q - ys_q) : -err_t'(ys_q - ye_q);
        sx_d  = (xs_q < xe_q);
        sy_d  = (ys_q < ye_q);
        err_d = dx_d + dy_d;
        cx_d  = xs_q;
        cy_d  = ys_q;
      end
      DRAW: begin
        if (xfer) begin
          cnt_d = cnt_q + 1'b1;
          if (!at_end) begin
            err_d = err_q + (step_x ? dy_q : '0) + (step_y ? dx_q : '0);
            if (step_x) cx_d = sx_q ? cx_q + 1'b1 : cx_q - 1'b1;
            if (step_y) cy_d = sy_q ? cy_q + 1'b1 : cy_q - 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xs_q  <= '0;
      ys_q  <= '0;
      xe_q  <= '0;
      ye_q  <= '0;
      cx_q  <= '0;
      cy_q  <= '0;
      dx_q  <= '0;
      dy_q  <= '0;
      err_q <= '0;
      sx_q  <= 1'b0;
      sy_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      xs_q  <= xs_d;
      ys_q  <= ys_d;
      xe_q  <= xe_d;
      ye_q  <= ye_d;
      cx_q  <= cx_d;
      cy_q  <= cy_d;
      dx_q  <= dx_d;
      dy_q  <= dy_d;
      err_q <= err_d;
      sx_q  <= sx_d;
      sy_q  <= sy_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_line_draw_engine.sv
// Directed and randomized line requests checked against a plain-integer Bresenham model.
module tb_line_draw_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [9:0] x0, x1;
  logic [8:0] y0, y1;
  logic [9:0] pixel_x;
  logic [8:0] pixel_y;
  logic       pixel_valid;
  logic       pixel_ready;
  logic       busy;
  logic       write_done;
  logic [10:0] pixel_count;

  int total = 0;
  int bad   = 0;
  int expX[$];
  int expY[$];

  line_draw_engine dut (
    .clk(clk), .reset(reset), .start(start),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready), .busy(busy), .write_done(write_done),
    .pixel_count(pixel_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference rasteriser: clamp, then walk the line with signed integers.
  task automatic modelLine(input int ax, input int ay, input int bx, input int by);
    int dx, dy, sx, sy, err, e2, x, y;
    if (ax > 639) ax = 639;
    if (bx > 639) bx = 639;
    if (ay > 479) ay = 479;
    if (by > 479) by = 479;
    expX.delete();
    expY.delete();
    dx  = (bx > ax) ? bx - ax : ax - bx;
    dy  = (by > ay) ? ay - by : by - ay;
    sx  = (ax < bx) ? 1 : -1;
    sy  = (ay < by) ? 1 : -1;
    err = dx + dy;
    x   = ax;
    y   = ay;
    while (1) begin
      expX.push_back(x);
      expY.push_back(y);
      if (x == bx && y == by) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endtask

  task automatic applyStimulus(input int ax, input int ay, input int bx, input int by,
                               input int readyPct, input logic [31:0] readyMask,
                               input bit useMask, input int pulseAt);
    int cyc, n;
    logic rdy;
    bit holdPending;
    logic [9:0] lastX;
    logic [8:0] lastY;
    modelLine(ax, ay, bx, by);
    n = expX.size();
    @(negedge clk);
    start = 1'b1;
    x0 = 10'(ax); y0 = 9'(ay); x1 = 10'(bx); y1 = 9'(by);
    @(negedge clk);
    start = 1'b0;
    x0 = 10'($urandom); y0 = 9'($urandom); x1 = 10'($urandom); y1 = 9'($urandom);
    checkOutput("setupBusy", 32'(busy), 1);
    checkOutput("setupValid", 32'(pixel_valid), 0);
    @(negedge clk);
    checkOutput("firstValid", 32'(pixel_valid), 1);
    cyc = 0;
    holdPending = 1'b0;
    lastX = '0;
    lastY = '0;
    while (expX.size() > 0 && cyc < 4000) begin
      if (holdPending) begin
        checkOutput("holdValid", 32'(pixel_valid), 1);
        checkOutput("holdX", 32'(pixel_x), 32'(lastX));
        checkOutput("holdY", 32'(pixel_y), 32'(lastY));
      end
      if (useMask) rdy = (cyc < 32) ? readyMask[cyc] : 1'b1;
      else         rdy = ($urandom_range(99) < readyPct);
      pixel_ready = rdy;
      if (cyc == pulseAt) begin
        start = 1'b1;
        x0 = 10'($urandom_range(639)); y0 = 9'($urandom_range(479));
        x1 = 10'($urandom_range(639)); y1 = 9'($urandom_range(479));
      end else begin
        start = 1'b0;
      end
      if (pixel_valid && rdy) begin
        checkOutput("pixX", 32'(pixel_x), expX.pop_front());
        checkOutput("pixY", 32'(pixel_y), expY.pop_front());
        holdPending = 1'b0;
      end else begin
        holdPending = pixel_valid;
        lastX = pixel_x;
        lastY = pixel_y;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    checkOutput("leftoverPixels", expX.size(), 0);
    checkOutput("writeDone", 32'(write_done), 1);
    checkOutput("doneValid", 32'(pixel_valid), 0);
    checkOutput("doneBusy", 32'(busy), 0);
    checkOutput("pixelCount", 32'(pixel_count), n);
  endtask

  initial begin
    int ax, ay, bx, by;
    reset = 1'b1;
    start = 1'b0;
    pixel_ready = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    #1;
    checkOutput("rstX", 32'(pixel_x), 0);
    checkOutput("rstY", 32'(pixel_y), 0);
    checkOutput("rstValid", 32'(pixel_valid), 0);
    checkOutput("rstBusy", 32'(busy), 0);
    checkOutput("rstDone", 32'(write_done), 0);
    checkOutput("rstCount", 32'(pixel_count), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    applyStimulus(0, 0, 3, 0, 100, 32'h0, 1'b0, -1);
    applyStimulus(0, 0, 1, 3, 100, 32'h0, 1'b0, -1);
    applyStimulus(3, 2, 0, 0, 100, 32'h0, 1'b0, -1);
    applyStimulus(5, 5, 7, 5, 100, 32'hFFFF_FFF1, 1'b1, -1);
    applyStimulus(10, 20, 10, 20, 100, 32'h0, 1'b0, -1);
    applyStimulus(630, 470, 700, 500, 100, 32'h0, 1'b0, 3);

    // Abandon a line after two transfers.
    @(negedge clk);
    start = 1'b1;
    x0 = 10'd0; y0 = 9'd0; x1 = 10'd9; y1 = 9'd0;
    pixel_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checkOutput("preRstCount", 32'(pixel_count), 2);
    checkOutput("preRstX", 32'(pixel_x), 2);
    #1 reset = 1'b1;
    #1;
    checkOutput("midRstX", 32'(pixel_x), 0);
    checkOutput("midRstValid", 32'(pixel_valid), 0);
    checkOutput("midRstBusy", 32'(busy), 0);
    checkOutput("midRstDone", 32'(write_done), 0);
    checkOutput("midRstCount", 32'(pixel_count), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("postRstValid", 32'(pixel_valid), 0);
    checkOutput("postRstDone", 32'(write_done), 0);
    applyStimulus(2, 7, 11, 3, 100, 32'h0, 1'b0, -1);

    for (int i = 0; i < 8; i++) begin
      if (i < 4) begin
        ax = $urandom_range(40); ay = $urandom_range(40);
        bx = $urandom_range(40); by = $urandom_range(40);
      end else begin
        ax = $urandom_range(1023); ay = $urandom_range(511);
        bx = $urandom_range(1023); by = $urandom_range(511);
      end
      applyStimulus(ax, ay, bx, by, 60, 32'h0, 1'b0, (i == 5) ? 7 : -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/line_draw_engine.md
Name: line_draw_engine

Overview:
- Bresenham line rasteriser; sits directly upstream of the screen-clear scanner.
- Accepts one line request (two endpoints) and emits one pixel coordinate per handshake toward the frame-buffer writer.
- Holds write_done high once the final pixel is accepted; the clear scanner uses this level to start its sweep.

Parameters:
- X_W, 10, x coordinate width
- Y_W, 9, y coordinate width
- X_MAX, 639, largest legal x; larger endpoint x values are clamped to this
- Y_MAX, 479, largest legal y; larger endpoint y values are clamped to this

Ports:
- clk  in  1  single system clock; all logic on posedge
- reset  in  1  asynchronous, active-high reset
- start  in  1  line request strobe; sampled only in IDLE or DONE
- x0  in  X_W  start point x
- y0  in  Y_W  start point y
- x1  in  X_W  end point x
- y1  in  Y_W  end point y
- pixel_x  out  X_W  current pixel x
- pixel_y  out  Y_W  current pixel y
- pixel_valid  out  1  pixel_x/pixel_y hold a valid pixel
- pixel_ready  in  1  downstream accepts the pixel; a transfer occurs when valid & ready
- busy  out  1  high in SETUP and DRAW
- write_done  out  1  level; line complete
- pixel_count  out  X_W+1  pixels transferred for the current line

Behaviour:
- Reset (async, immediate): state=IDLE; pixel_x=0, pixel_y=0, pixel_valid=0, busy=0, write_done=0, pixel_count=0; all internal registers 0.
- States: IDLE, SETUP, DRAW, DONE.
- IDLE/DONE, start=1:
  - Latch the clamped endpoints.
  - Clear write_done and pixel_count.
  - Go to SETUP.
  - start is ignored in SETUP and DRAW.
- SETUP (1 cycle):
  - dx = |x1-x0|, dy = -|y1-y0|.
  - sx = +1 if x0<x1, else -1; sy = +1 if y0<y1, else -1.
  - err = dx+dy; current point = (x0,y0).
  - Go to DRAW.
- Latency: first pixel_valid is 2 cycles after the start edge.
- DRAW:
  - pixel_valid=1; pixel_x/pixel_y = current point, held stable while ready=0.
  - On transfer: pixel_count+1.
  - On transfer at the endpoint: go to DONE.
  - On transfer otherwise: e2 = 2*err.
    - If e2 >= dy: err += dy, x += sx.
    - If e2 <= dx: err += dx, y += sy.
    - Both updates use the old err and apply in the same cycle.
  - One pixel per cycle when ready is held high.
- DONE: write_done=1, pixel_valid=0, busy=0; remain until start or reset.
- Arithmetic:
  - dx, dy, err and e2 are signed, max(X_W,Y_W)+2 bits; no overflow possible for 640x480.
  - Steps never leave [0,X_MAX] x [0,Y_MAX].
- Degenerate line (x0==x1 and y0==y1): exactly one pixel, then DONE.
- Reset during DRAW: line is abandoned; no further pixels; write_done stays 0.
- Total pixels per line = max(dx,-dy)+1.

Decomposition:
- draw_pkg holds:
  - state enum (IDLE, SETUP, DRAW, DONE)
  - X_W/Y_W defaults and SCREEN_W=640, SCREEN_H=480 constants
  - signed error-term typedef
- Sub-module clamp_coord (min against max parameter) is natural for endpoint latching; all other logic is a single module.

Test Plan:
- Horizontal line (0,0)->(3,0), ready=1 -> pixels (0,0),(1,0),(2,0),(3,0) on consecutive cycles; write_done rises the cycle after the 4th transfer; pixel_count=4.
- Steep line (0,0)->(1,3) -> (0,0),(0,1),(1,2),(1,3); reversed line (3,2)->(0,0) -> (3,2),(2,1),(1,1),(0,0).
- Backpressure: line (5,5)->(7,5) with ready low for 3 cycles at pixel (6,5) -> (6,5) held stable with valid=1; no pixel skipped or duplicated; 3 transfers total.
- Single point (10,20)->(10,20) -> exactly one pixel (10,20), then write_done=1.
- Clamp and start while busy: (630,470)->(700,500) draws to endpoint (639,479); a start pulse mid-DRAW with new endpoints is ignored.
- Reset mid-line: assert reset after the 2nd pixel of (0,0)->(9,0) -> all outputs 0 immediately; a new start after release draws a full new line.
